cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache between the CPU request port and the 8x4 synchronous word memory (`memory`).
- Drives the memory's `clock`/`write`/`address`/`data_in` and consumes its registered `data_out`.
- One word per line: 4 lines, 2-bit index, 1-bit tag.

Parameters:
- ADDR_WIDTH, 3, word address width; matches the memory.
- DATA_WIDTH, 4, word width; matches the memory.
- INDEX_WIDTH, 2, line index bits; line count = 2**INDEX_WIDTH; tag width = ADDR_WIDTH-INDEX_WIDTH.

Ports:
- clock  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  request valid; held until cpu_ready.
- cpu_write  input  1  1=write, 0=read.
- cpu_address  input  ADDR_WIDTH  word address.
- cpu_data_in  input  DATA_WIDTH  write data.
- cpu_data_out  output  DATA_WIDTH  read data; valid while cpu_ready=1.
- cpu_ready  output  1  one-cycle completion pulse.
- mem_write  output  1  to memory write.
- mem_address  output  ADDR_WIDTH  to memory address.
- mem_data_out  output  DATA_WIDTH  to memory data_in.
- mem_data_in  input  DATA_WIDTH  from memory data_out; valid the cycle after the address is sampled.
- hit_count  output  8  hit counter (see Optional Feature).
- miss_count  output  8  miss counter (see Optional Feature).

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all valid=0, dirty=0; tags/data=0.
  - cpu_ready=0, cpu_data_out=0, mem_write=0, mem_address=0, mem_data_out=0, counters=0.
- Per-line storage: valid, dirty, tag, data word.
- Index = cpu_address[INDEX_WIDTH-1:0]; tag = upper bits.
- IDLE:
  - If cpu_req=1, latch write/address/data into request registers, then go to COMPARE.
  - Port changes while not in IDLE are ignored.
- COMPARE:
  - Hit (valid && tag match):
    - Read: cpu_data_out=line data.
    - Write: line data=req data, dirty=1; cpu_data_out=written data.
    - Assert cpu_ready for this cycle only, then go to IDLE.
  - Miss, line invalid or clean: go to ALLOCATE.
  - Miss, line valid and dirty: go to WRITEBACK.
  - Hit/miss is classified only on the first COMPARE of a request, not on the re-compare after FILL.
- WRITEBACK (1 cycle):
  - mem_write=1, mem_address={line tag, index}, mem_data_out=line data.
  - Go to ALLOCATE.
- ALLOCATE (1 cycle):
  - mem_write=0, mem_address=req address; the memory samples it at the closing edge.
  - Go to FILL.
- FILL (1 cycle):
  - Capture mem_data_in into the line; tag=req tag, valid=1, dirty=0.
  - Go to COMPARE, which now hits and completes the request.
- mem_write is 1 only in WRITEBACK.
- mem_address holds its last value outside WRITEBACK/ALLOCATE; mem_data_out likewise.
- Latency, measured from the edge that samples cpu_req to cpu_ready high:
  - Hit: 1 cycle.
  - Clean miss: 4 cycles.
  - Dirty miss: 5 cycles.
- Handshake:
  - After cpu_ready, the controller spends ≥1 cycle in IDLE.
  - cpu_req still high in that IDLE cycle starts a new request, so the requester drops cpu_req on cpu_ready.
- Boundaries:
  - Write miss allocates first, then writes the line (dirty=1); memory is not updated.
  - Same-index, different-tag access evicts the line; a dirty victim is written back before the fill.
  - Address 7 / index 3 wrap needs no special case.
  - Reset during WRITEBACK deasserts mem_write immediately; no memory write occurs unless the edge already passed.
  - Reset mid-request drops the request without a cpu_ready.
  - Dirty data is lost on reset; this is accepted.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined:
  - hit_count increments on each first-COMPARE hit.
  - miss_count increments on each first-COMPARE miss.
  - Both are 8-bit, saturate at 255, and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Shared package cache_pkg holds:
  - State encoding IDLE=0, COMPARE=1, WRITEBACK=2, ALLOCATE=3, FILL=4 (3 bits).
  - Width constants ADDR_WIDTH, DATA_WIDTH, INDEX_WIDTH, TAG_WIDTH.
- One sub-module, cache_line_array:
  - Storage for valid/dirty/tag/data with async reset.
  - Combinational read by index.
  - Write port with separate enables for fill and CPU write.
- FSM and datapath stay in cache_controller.

Test Plan:
- Reset, then read addr 0:
  - Miss: mem_address=0 in ALLOCATE; cpu_ready 4 cycles after acceptance, cpu_data_out=4'b0011.
  - No mem_write pulse.
- Read addr 0 again: hit, cpu_ready 1 cycle after acceptance, cpu_data_out=4'b0011, mem_write stays 0.
- Write addr 1 data 4'b1010:
  - Miss-allocate, then cpu_ready.
  - Memory word 1 is still 4'b0000.
  - A following read of addr 1 hits and returns 4'b1010.
- Read addr 5 (index 1, tag 1) after the previous test:
  - WRITEBACK cycle with mem_write=1, mem_address=1, mem_data_out=4'b1010.
  - Fill from address 5; cpu_ready at 5 cycles with 4'b0000.
  - Memory word 1 is now 4'b1010.
- Assert reset during WRITEBACK: mem_write drops immediately, no cpu_ready, state=IDLE, and a read of addr 0 misses again.
- With CACHE_STATS_EN, run the sequence: read 0, read 0, write 1, read 5 → hit_count=1, miss_count=3.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths and FSM state encoding for the direct-mapped cache controller.
package cache_pkg;
    localparam int ADDR_WIDTH  = 3;
    localparam int DATA_WIDTH  = 4;
    localparam int INDEX_WIDTH = 2;
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        FILL      = 3'd4
    } state_t;
endpackage

// File: rtl/cache_line_array.sv
// Per-line valid/dirty/tag/data storage: combinational read by index,
// separate fill and CPU-write enables (fill wins if both are asserted).
module cache_line_array
    import cache_pkg::*;
#(
    parameter int IDX_W  = cache_pkg::INDEX_WIDTH,
    parameter int TAG_W  = cache_pkg::TAG_WIDTH,
    parameter int DATA_W = cache_pkg::DATA_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [IDX_W-1:0]  i_index,
    input  logic              i_fill_we,
    input  logic [TAG_W-1:0]  i_fill_tag,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic              i_cpu_we,
    input  logic [DATA_W-1:0] i_cpu_data,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TAG_W-1:0]  o_tag,
    output logic [DATA_W-1:0] o_data
);
    localparam int unsigned LINES = 2**IDX_W;

    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int unsigned i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
            r_tag[i_index]   <= i_fill_tag;
            r_data[i_index]  <= i_fill_data;
        end else if (i_cpu_we) begin
            r_dirty[i_index] <= 1'b1;
            r_data[i_index]  <= i_cpu_data;
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back/write-allocate cache in front of a registered word memory.
// Optional hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = cache_pkg::DATA_WIDTH,
    parameter int INDEX_WIDTH = cache_pkg::INDEX_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_data_in,
    output logic [DATA_WIDTH-1:0] cpu_data_out,
    output logic                  cpu_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [7:0]            hit_count,
    output logic [7:0]            miss_count
);
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;

    state_t                r_state;
    logic                  r_req_write;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_data;

    logic [INDEX_WIDTH-1:0] w_index;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_line_valid;
    logic                   w_line_dirty;
    logic [TAG_W-1:0]       w_line_tag;
    logic [DATA_WIDTH-1:0]  w_line_data;
    logic                   w_hit;
    logic                   w_fill_we;
    logic                   w_cpu_we;

    assign w_index   = r_req_addr[INDEX_WIDTH-1:0];
    assign w_tag     = r_req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign w_hit     = w_line_valid && (w_line_tag == w_tag);
    assign w_fill_we = (r_state == FILL);
    assign w_cpu_we  = (r_state == COMPARE) && w_hit && r_req_write;

    cache_line_array #(
        .IDX_W  (INDEX_WIDTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_WIDTH)
    ) u_lines (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_index     (w_index),
        .i_fill_we   (w_fill_we),
        .i_fill_tag  (w_tag),
        .i_fill_data (mem_data_in),
        .i_cpu_we    (w_cpu_we),
        .i_cpu_data  (r_req_data),
        .o_valid     (w_line_valid),
        .o_dirty     (w_line_dirty),
        .o_tag       (w_line_tag),
        .o_data      (w_line_data)
    );

    // Memory-side outputs are loaded on entry to WRITEBACK/ALLOCATE so the
    // memory sees them for the whole state and samples them on its closing edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_write  <= 1'b0;
            r_req_addr   <= '0;
            r_req_data   <= '0;
            cpu_ready    <= 1'b0;
            cpu_data_out <= '0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_data_out <= '0;
        end else begin
            cpu_ready <= 1'b0;
            mem_write <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_req_write <= cpu_write;
                        r_req_addr  <= cpu_address;
                        r_req_data  <= cpu_data_in;
                        r_state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        cpu_data_out <= r_req_write ? r_req_data : w_line_data;
                        cpu_ready    <= 1'b1;
                        r_state      <= IDLE;
                    end else if (w_line_valid && w_line_dirty) begin
                        mem_write    <= 1'b1;
                        mem_address  <= {w_line_tag, w_index};
                        mem_data_out <= w_line_data;
                        r_state      <= WRITEBACK;
                    end else begin
                        mem_address <= r_req_addr;
                        r_state     <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    mem_address <= r_req_addr;
                    r_state     <= ALLOCATE;
                end
                ALLOCATE: r_state <= FILL;
                FILL:     r_state <= COMPARE;
                default:  r_state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Set after a fill so the re-compare that completes a miss is not counted as a hit.
    logic r_refill;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_refill <= 1'b0;
        end else if (r_state == FILL) begin
            r_refill <= 1'b1;
        end else if (r_state == IDLE) begin
            r_refill <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((r_state == COMPARE) && !r_refill) begin
            if (w_hit) begin
                if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            end else begin
                if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: behavioural cache/memory model feeds
// expected responses and write-backs into queues checked by a monitor.
module tb_cache_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_write = 1'b0;
    logic [2:0] cpu_address = '0;
    logic [3:0] cpu_data_in = '0;
    logic [3:0] cpu_data_out;
    logic       cpu_ready;
    logic       mem_write;
    logic [2:0] mem_address;
    logic [3:0] mem_data_out;
    logic [3:0] mem_data_in = '0;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit aborted  = 1'b0;

    cache_controller #(.ADDR_WIDTH(3), .DATA_WIDTH(4), .INDEX_WIDTH(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_write    (cpu_write),
        .cpu_address  (cpu_address),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_ready    (cpu_ready),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // 8x4 synchronous memory with registered read data
    logic [3:0] mem [8];
    always @(posedge clock) begin
        if (mem_write) mem[mem_address] <= mem_data_out;
        mem_data_in <= mem[mem_address];
    end

    // Reference model
    logic [3:0] ref_mem [8];
    bit         m_valid [4];
    bit         m_dirty [4];
    bit         m_tag   [4];
    logic [3:0] m_data  [4];
    int         m_hits = 0;
    int         m_misses = 0;

    typedef struct {
        logic [3:0] data;
        int         acc;
        int         lat;
        logic [2:0] addr;
    } exp_t;
    typedef struct {
        logic [2:0] a;
        logic [3:0] d;
    } wb_t;
    exp_t exp_q[$];
    wb_t  wb_q[$];

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 1'b0;
            m_data[i]  = '0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_req(input bit wr, input logic [2:0] a, input logic [3:0] d, input int acc);
        exp_t e;
        wb_t  w;
        int   idx;
        bit   tg;
        idx = int'(a) % 4;
        tg  = a[2];
        if (m_valid[idx] && m_tag[idx] == tg) begin
            e.lat = 1;
            if (m_hits < 255) m_hits++;
        end else begin
            if (m_misses < 255) m_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                e.lat = 5;
                w.a = 3'(int'(m_tag[idx]) * 4 + idx);
                w.d = m_data[idx];
                wb_q.push_back(w);
                ref_mem[w.a] = w.d;
            end else begin
                e.lat = 4;
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_data[idx]  = ref_mem[a];
        end
        if (wr) begin
            m_data[idx]  = d;
            m_dirty[idx] = 1'b1;
        end
        e.data = m_data[idx];
        e.acc  = acc;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    // Monitor: checks every completion and every memory write against the queues
    always @(negedge clock) begin
        if (!reset) begin
            if (cpu_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cpu_ready", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("rd_data@%0d", e.addr), int'(cpu_data_out), int'(e.data));
                    chk($sformatf("latency@%0d", e.addr), cyc - e.acc, e.lat);
                end
            end
            if (mem_write) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_mem_write", 1, 0);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    chk("wb_addr", int'(mem_address), int'(w.a));
                    chk("wb_data", int'(mem_data_out), int'(w.d));
                end
            end
        end
    end

    task automatic do_req(input bit wr, input logic [2:0] a, input logic [3:0] d);
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        model_req(wr, a, d, cyc + 1);
        cpu_req     = 1'b1;
        cpu_write   = wr;
        cpu_address = a;
        cpu_data_in = d;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (cpu_ready) begin
                seen = 1'b1;
                break;
            end
        end
        cpu_req = 1'b0;
        if (!seen) begin
            chk("cpu_ready_timeout", 0, 1);
            aborted = 1'b1;
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef CACHE_STATS_EN
        chk({"hit_count_", tag}, int'(hit_count), m_hits);
        chk({"miss_count_", tag}, int'(miss_count), m_misses);
`else
        chk({"hit_count_", tag}, int'(hit_count), 0);
        chk({"miss_count_", tag}, int'(miss_count), 0);
`endif
    endtask

    initial begin
        logic [3:0] init_vals [8];
        bit seen;
        init_vals = '{4'b0011, 4'b0000, 4'b0101, 4'b1001, 4'b1100, 4'b0000, 4'b0110, 4'b1111};
        for (int i = 0; i < 8; i++) begin
            mem[i]     = init_vals[i];
            ref_mem[i] = init_vals[i];
        end
        model_reset();

        // Reset state
        #12;
        chk("rst_cpu_ready", int'(cpu_ready), 0);
        chk("rst_cpu_data_out", int'(cpu_data_out), 0);
        chk("rst_mem_write", int'(mem_write), 0);
        chk("rst_mem_address", int'(mem_address), 0);
        chk("rst_mem_data_out", int'(mem_data_out), 0);
        check_counters("rst");
        @(negedge clock);
        reset = 1'b0;

        // Directed: clean read miss, hit, write miss, dirty eviction
        do_req(1'b0, 3'd0, 4'b0000);
        do_req(1'b0, 3'd0, 4'b0000);
        do_req(1'b1, 3'd1, 4'b1010);
        chk("mem1_after_write_miss", int'(mem[1]), 0);
        do_req(1'b0, 3'd5, 4'b0000);
        chk("mem1_after_writeback", int'(mem[1]), 4'b1010);
        check_counters("seq");

        // Reset in the middle of a write-back
        do_req(1'b1, 3'd2, 4'b0111);
        @(negedge clock);
        cpu_req     = 1'b1;
        cpu_write   = 1'b0;
        cpu_address = 3'd6;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clock);
            #1;
            if (mem_write) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wb_reached", int'(seen), 1);
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("rst_mid_wb_mem_write", int'(mem_write), 0);
        chk("rst_mid_wb_cpu_ready", int'(cpu_ready), 0);
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("mem2_not_written", int'(mem[2]), int'(ref_mem[2]));
        do_req(1'b0, 3'd0, 4'b0000);

        // Random traffic
        for (int i = 0; i < 600 && !aborted; i++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clock);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mem_image_%0d", i), int'(mem[i]), int'(ref_mem[i]));
        end
        check_counters("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
